// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants and a small range helper for the VGA timing controller.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int unsigned CNT_W = 10;

    function automatic logic in_range(input logic [CNT_W-1:0] val, input int unsigned lo,
                                      input int unsigned hi);
        return (32'(val) >= lo) && (32'(val) <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Free-running pixel phase counter; flags the first and last system clock of each pixel period.
module vga_pixel_tick #(
    parameter int unsigned CLKS_PER_PIXEL = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_first,
    output logic o_last
);

    localparam int unsigned PW = $clog2(CLKS_PER_PIXEL);

    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_next;

    always_comb begin
        w_phase_next = r_phase + PW'(1);
        if (o_last) begin
            w_phase_next = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    assign o_first = (r_phase == '0);
    assign o_last  = (r_phase == PW'(CLKS_PER_PIXEL - 1));

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: walks the fetch position, requests pixels, and registers rgb/hsync/vsync
// together at each pixel boundary so all three leave the block aligned.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLKS_PER_PIXEL = 4,
    parameter int unsigned H_VISIBLE      = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT        = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC         = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK         = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE      = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT        = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC         = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK         = vga_timing_pkg::V_BACK
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_next_rgb,
    output logic       o_request,
    output logic [9:0] o_hcount,
    output logic [8:0] o_vcount,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [7:0] o_rgb,
    output logic       o_frame_start
);

    localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    // The downstream glyph path needs three clocks between request and capture.
    if (CLKS_PER_PIXEL < 4) begin : g_cpp_check
        $error("CLKS_PER_PIXEL must be at least 4");
    end
    if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_cnt_check
        $error("raster does not fit the position counters");
    end

    logic w_first;
    logic w_last;

    vga_pixel_tick #(
        .CLKS_PER_PIXEL(CLKS_PER_PIXEL)
    ) u_pixel_tick (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_first(w_first),
        .o_last (w_last)
    );

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic [7:0]       r_rgb;

    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_active;
    logic             w_h_end;
    logic             w_v_end;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic [7:0]       w_rgb_next;

    assign w_active = (r_h < CNT_W'(H_VISIBLE)) && (r_v < CNT_W'(V_VISIBLE));
    assign w_h_end  = (r_h == CNT_W'(H_TOT - 1));
    assign w_v_end  = (r_v == CNT_W'(V_TOT - 1));

    always_comb begin
        w_h_next = r_h + CNT_W'(1);
        w_v_next = r_v;
        if (w_h_end) begin
            w_h_next = '0;
            w_v_next = w_v_end ? '0 : r_v + CNT_W'(1);
        end
    end

    // Output decode uses the position of the pixel that is just ending.
    always_comb begin
        w_hsync_next = !in_range(r_h, HS_START, HS_END);
        w_vsync_next = !in_range(r_v, VS_START, VS_END);
        w_rgb_next   = w_active ? i_next_rgb : 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h     <= '0;
            r_v     <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 8'h00;
        end else if (w_last) begin
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_rgb   <= w_rgb_next;
        end
    end

    assign o_request     = w_first && w_active;
    assign o_frame_start = w_first && (r_h == '0) && (r_v == '0);
    assign o_hcount      = r_h;
    assign o_vcount      = r_v[8:0];
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_rgb         = r_rgb;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomized bench: two controllers (standard 640x480 and a tiny raster) checked every cycle
// against an absolute-time raster model, plus literal timing landmarks.
module tb_vga_timing_controller;

    localparam int unsigned CPP = 4;
    localparam int unsigned HV = 640, HF = 16, HS = 96, HB = 48, HT = 800;
    localparam int unsigned VV = 480, VF = 10, VS = 2, VB = 33, VT = 525;

    localparam int unsigned S_CPP = 5;
    localparam int unsigned S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3, S_HT = 16;
    localparam int unsigned S_VV = 4, S_VF = 1, S_VS = 2, S_VB = 1, S_VT = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] next_rgb;
    logic [7:0] s_next_rgb;

    logic       o_request, o_hsync, o_vsync, o_frame_start;
    logic [9:0] o_hcount;
    logic [8:0] o_vcount;
    logic [7:0] o_rgb;

    logic       s_request, s_hsync, s_vsync, s_frame_start;
    logic [9:0] s_hcount;
    logic [8:0] s_vcount;
    logic [7:0] s_rgb;

    int unsigned total = 0;
    int unsigned bad   = 0;

    vga_timing_controller u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_next_rgb   (next_rgb),
        .o_request    (o_request),
        .o_hcount     (o_hcount),
        .o_vcount     (o_vcount),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync),
        .o_rgb        (o_rgb),
        .o_frame_start(o_frame_start)
    );

    vga_timing_controller #(
        .CLKS_PER_PIXEL(S_CPP),
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_next_rgb   (s_next_rgb),
        .o_request    (s_request),
        .o_hcount     (s_hcount),
        .o_vcount     (s_vcount),
        .o_hsync      (s_hsync),
        .o_vsync      (s_vsync),
        .o_rgb        (s_rgb),
        .o_frame_start(s_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned hpos(int unsigned n, int unsigned cpp, int unsigned ht);
        return (n / cpp) % ht;
    endfunction

    function automatic int unsigned vpos(int unsigned n, int unsigned cpp, int unsigned ht,
                                         int unsigned vt);
        return (n / cpp / ht) % vt;
    endfunction

    function automatic logic inr(int unsigned x, int unsigned lo, int unsigned hi);
        return (x >= lo) && (x <= hi);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: n counts clocks since reset release; the raster position is pure arithmetic on n.
    int unsigned m_n = 0, s_n = 0;
    logic [7:0]  m_rgb = 8'h00, s_rgbm = 8'h00;
    logic        m_hs = 1'b1, m_vs = 1'b1, s_hs = 1'b1, s_vs = 1'b1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n <= 0; m_rgb <= 8'h00; m_hs <= 1'b1; m_vs <= 1'b1;
        end else begin
            if (m_n % CPP == CPP - 1) begin
                m_rgb <= (hpos(m_n, CPP, HT) < HV && vpos(m_n, CPP, HT, VT) < VV) ?
                         next_rgb : 8'h00;
                m_hs  <= !inr(hpos(m_n, CPP, HT), HV + HF, HV + HF + HS - 1);
                m_vs  <= !inr(vpos(m_n, CPP, HT, VT), VV + VF, VV + VF + VS - 1);
            end
            m_n <= m_n + 1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            s_n <= 0; s_rgbm <= 8'h00; s_hs <= 1'b1; s_vs <= 1'b1;
        end else begin
            if (s_n % S_CPP == S_CPP - 1) begin
                s_rgbm <= (hpos(s_n, S_CPP, S_HT) < S_HV && vpos(s_n, S_CPP, S_HT, S_VT) < S_VV) ?
                          s_next_rgb : 8'h00;
                s_hs   <= !inr(hpos(s_n, S_CPP, S_HT), S_HV + S_HF, S_HV + S_HF + S_HS - 1);
                s_vs   <= !inr(vpos(s_n, S_CPP, S_HT, S_VT), S_VV + S_VF, S_VV + S_VF + S_VS - 1);
            end
            s_n <= s_n + 1;
        end
    end

    task automatic check_dut(input string tag, input int unsigned n, input int unsigned cpp,
                             input int unsigned ht, input int unsigned vt, input int unsigned hv,
                             input int unsigned vv, input logic req, input logic fs,
                             input logic [9:0] hc, input logic [8:0] vc, input logic hs,
                             input logic vs, input logic [7:0] rgb, input logic e_hs,
                             input logic e_vs, input logic [7:0] e_rgb);
        int unsigned h = hpos(n, cpp, ht);
        int unsigned v = vpos(n, cpp, ht, vt);
        logic a = (h < hv) && (v < vv);
        logic p0 = (n % cpp == 0);
        chk({tag, ".request"}, 32'(req), 32'(p0 && a));
        chk({tag, ".frame_start"}, 32'(fs), 32'(p0 && h == 0 && v == 0));
        chk({tag, ".hcount"}, 32'(hc), h);
        if (a) chk({tag, ".vcount"}, 32'(vc), v);
        chk({tag, ".hsync"}, 32'(hs), 32'(e_hs));
        chk({tag, ".vsync"}, 32'(vs), 32'(e_vs));
        chk({tag, ".rgb"}, 32'(rgb), 32'(e_rgb));
    endtask

    always @(negedge clk) begin
        check_dut("main", m_n, CPP, HT, VT, HV, VV, o_request, o_frame_start, o_hcount,
                  o_vcount, o_hsync, o_vsync, o_rgb, m_hs, m_vs, m_rgb);
        check_dut("small", s_n, S_CPP, S_HT, S_VT, S_HV, S_VV, s_request, s_frame_start,
                  s_hcount, s_vcount, s_hsync, s_vsync, s_rgb, s_hs, s_vs, s_rgbm);
    end

    // Small raster: frame period and vsync low time, measured between frame_start pulses.
    int unsigned s_last_fs = 0, s_vlow = 0;
    always @(negedge clk) begin
        if (s_frame_start && s_n != 0) begin
            chk("small.frame_period", s_n - s_last_fs, S_CPP * S_HT * S_VT);
            chk("small.vsync_low_clks", s_vlow, S_CPP * S_HT * S_VS);
        end
        if (s_frame_start) s_last_fs <= s_n;
        s_vlow <= (s_frame_start ? 0 : s_vlow) + ((s_vsync == 1'b0) ? 1 : 0);
    end

    // Main raster landmarks over the first lines after release.
    logic        meas_en = 1'b0;
    int unsigned req0 = 0, line1_at = 0, hs_low0 = 0, hs_fall0 = 0;
    logic [7:0]  rgb37 = 8'h00;
    always @(negedge clk) begin
        if (meas_en && rst_n) begin
            if (o_request && m_n < HT * CPP) req0 <= req0 + 1;
            if (o_request && o_hcount == 0 && o_vcount == 1 && line1_at == 0) line1_at <= m_n;
            if (!o_hsync && m_n < HT * CPP) begin
                hs_low0 <= hs_low0 + 1;
                if (hs_fall0 == 0) hs_fall0 <= m_n;
            end
            if (m_n == 38 * CPP) rgb37 <= o_rgb;
        end
    end

    // mode 0: random every clock; 1: pixel-gen model (hcount[7:0] from phase 3); 2: constant FF
    task automatic drive(input int md);
        int unsigned h = hpos(m_n, CPP, HT);
        case (md)
            0:       next_rgb = 8'($urandom);
            1:       next_rgb = (m_n % CPP == CPP - 1) ? h[7:0] : 8'($urandom);
            default: next_rgb = 8'hFF;
        endcase
        s_next_rgb = 8'($urandom);
    endtask

    task automatic run(input int unsigned cycles, input int md);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            drive(md);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        next_rgb   = 8'h00;
        s_next_rgb = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        meas_en = 1'b1;
        drive(1);
        @(negedge clk);
        chk("rel.request", 32'(o_request), 1);
        chk("rel.frame_start", 32'(o_frame_start), 1);
        chk("rel.hcount", 32'(o_hcount), 0);
        chk("rel.vcount", 32'(o_vcount), 0);
        chk("rel.hsync", 32'(o_hsync), 1);
        chk("rel.vsync", 32'(o_vsync), 1);
        chk("rel.rgb", 32'(o_rgb), 0);

        run(2 * HT * CPP + 200, 1);
        meas_en = 1'b0;
        chk("line0.requests", req0, 640);
        chk("line1.first_request_at", line1_at, 3200);
        chk("line0.hsync_low_clks", hs_low0, 384);
        chk("line0.hsync_fall_at", hs_fall0, 2628);
        chk("pixel37.rgb", 32'(rgb37), 32'h25);

        run(HT * CPP, 2);
        run(1234 + $urandom_range(0, 1500), 0);

        rst_n = 1'b0;
        run(3, 0);
        @(negedge clk);
        chk("midrst.hsync", 32'(o_hsync), 1);
        chk("midrst.vsync", 32'(o_vsync), 1);
        chk("midrst.rgb", 32'(o_rgb), 0);
        chk("midrst.hcount", 32'(o_hcount), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0);
        @(negedge clk);
        chk("rel2.request", 32'(o_request), 1);
        chk("rel2.frame_start", 32'(o_frame_start), 1);

        run(2 * HT * CPP, 0);
        run(HT * CPP, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
